demux_stream_1ton: RTL and testbench
====================================

// Module: demux_stream_1ton
// PURPOSE
//  Registered 1-to-N stream demultiplexer with valid/ready flow control.
//  Routes each accepted input beat to exactly one of N_CH output channels.
//  Channel comes from sel_i (SELECT mode) or an internal round-robin pointer (RR mode).
//  Replaces the combinational 1-to-8 demux wherever the data path is clocked and back-pressured.
// PARAMETERS
//  DATA_W  8                 data width per beat
//  N_CH    8                 number of output channels, 2..16, need not be a power of 2
//  SEL_W   $clog2(N_CH)      select width (derived, do not override)
//  MODE    0                 0 = SELECT (sel_i chooses), 1 = RR (round-robin, sel_i ignored)
// PORTS
//  clk        in   1             single clock, rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  d_i        in   DATA_W        input data
//  sel_i      in   SEL_W         target channel, SELECT mode only
//  valid_i    in   1             input beat valid
//  ready_o    out  1             input beat accepted when valid_i & ready_o
//  y_o        out  DATA_W        output data, shared by all channels
//  y_valid_o  out  N_CH          one-hot valid; bit k = beat is for channel k
//  y_ready_i  in   N_CH          per-channel ready from downstream
//  ch_o       out  SEL_W         index of the channel currently held
//  err_o      out  1             1-cycle pulse: beat dropped because sel_i >= N_CH
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - y_valid_o = 0, y_o = 0, ch_o = 0, err_o = 0.
//   - RR pointer = 0. ready_o = 1 after release.
//  Output stage: one register holding {data, ch, full}.
//   - y_valid_o = full ? (1 << ch) : 0.
//   - y_o and ch_o are driven from the register.
//   - Bits of y_valid_o other than bit ch are always 0.
//  Drain: drain = full & y_ready_i[ch]. Ready bits of other channels are ignored.
//  ready_o = !full | drain. Purely combinational; no dependency on valid_i.
//  Accept: acc = valid_i & ready_o. Target channel t:
//   - t = sel_i in SELECT mode.
//   - t = RR pointer in RR mode.
//  Latency: a beat accepted on edge n has y_valid_o set after edge n.
//   - Full throughput, 1 beat/cycle, while the target channel stays ready.
//  Simultaneous drain and accept: the register is overwritten with the new beat and full stays 1.
//  A drain without an accept clears full.
//  Out of range (SELECT mode, sel_i >= N_CH, possible only when N_CH is not a power of 2):
//   - The beat is accepted (handshake completes) and discarded.
//   - err_o = 1 for the following cycle.
//   - The register is not loaded. A simultaneous drain still clears full.
//  RR pointer:
//   - Advances on every acc, wrapping N_CH-1 -> 0.
//   - Never advances on stall.
//   - A stalled head-of-line channel blocks all channels, by design; there is no reordering.
//  Held beat stability: while full & !drain, y_o, ch_o and y_valid_o are held constant.
//  Reset mid-transfer: the held beat is lost and y_valid_o drops immediately (async).
//   - Upstream must re-send the beat.
//  Width rules: ch_o and the RR pointer are SEL_W bits. RR wrap is an explicit compare against N_CH-1.
// STRUCTURE
//  Shared package demux_pkg:
//   - localparams DEMUX_MODE_SELECT = 0 and DEMUX_MODE_RR = 1.
//   - function onehot(idx, n) used for y_valid_o.
//  One sub-module: demux_rr_ptr (modulo-N_CH counter with enable), instantiated only when MODE = 1.
//  Everything else stays flat in this file. No latches; one always_ff and one always_comb.
// TESTING  (run with N_CH = 8 and N_CH = 6, DATA_W = 8)
//  1. SELECT, all y_ready_i = 1; send d = 0xA5 sel = 3, then 0x5A sel = 7 back-to-back
//     -> y_valid_o = 0x08 / y_o = 0xA5, then 0x80 / 0x5A on consecutive cycles; ready_o stays 1.
//  2. SELECT, y_ready_i = 0xF7; send 0x11 sel = 3 then 0x22 sel = 0
//     -> 0x11 held, ready_o = 0; raise y_ready_i[3]
//     -> next cycle y_valid_o = 0x01 with y_o = 0x22.
//  3. RR, N_CH = 6, all ready; send 8 beats 0..7
//     -> channels 0,1,2,3,4,5,0,1 in order; pointer wraps at 5.
//  4. SELECT, N_CH = 6, sel = 6 with d = 0x33
//     -> handshake completes, err_o pulses once, y_valid_o stays 0.
//  5. Beat held on ch 2, assert rst_n = 0 mid-cycle
//     -> y_valid_o = 0 without waiting for a clock edge; after release a beat with sel = 4 appears only on bit 4.
//  6. Random valid/ready/sel for 10k cycles against a scoreboard
//     -> no loss, no duplication, order preserved, y_valid_o always one-hot or zero.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_MODE_SELECT = 0;
  localparam int unsigned DEMUX_MODE_RR     = 1;
  localparam int unsigned DEMUX_MAX_CH      = 16;

  // One-hot vector with bit idx set, or all zeros when idx is not a valid channel.
  function automatic logic [DEMUX_MAX_CH-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
    return (idx < n) ? (DEMUX_MAX_CH'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Modulo-N round-robin channel pointer, advancing once per enable.
module demux_rr_ptr
  import demux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: explicit wrap at N-1 so non-power-of-two N works.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N valid/ready stream demultiplexer with SELECT or round-robin routing.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH),
  parameter int unsigned MODE   = DEMUX_MODE_SELECT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] y_o,
  output logic [N_CH-1:0]   y_valid_o,
  input  logic [N_CH-1:0]   y_ready_i,
  output logic [SEL_W-1:0]  ch_o,
  output logic              err_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  tgt;
  logic [N_CH-1:0]   held_oh;
  logic              drain;
  logic              acc;
  logic              in_range;

  // Round-robin pointer exists only in RR mode; it advances on every accepted beat.
  if (MODE == DEMUX_MODE_RR) begin : g_rr
    demux_rr_ptr #(
      .N (N_CH),
      .W (SEL_W)
    ) u_rr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (acc),
      .ptr_o (rr_ptr)
    );
  end else begin : g_sel
    assign rr_ptr = '0;
  end

  // Handshake, routing and next-state of the single output register.
  always_comb begin
    held_oh   = N_CH'(onehot(32'(ch_q), N_CH));
    y_valid_o = full_q ? held_oh : '0;
    drain     = full_q & (|(held_oh & y_ready_i));
    ready_o   = ~full_q | drain;
    acc       = valid_i & ready_o;
    tgt       = (MODE == DEMUX_MODE_RR) ? rr_ptr : sel_i;
    in_range  = (MODE == DEMUX_MODE_RR) || (32'(sel_i) < N_CH);

    data_d = data_q;
    ch_d   = ch_q;
    full_d = full_q;
    err_d  = acc & ~in_range;

    // A new in-range beat overwrites the register even while it drains;
    // a dropped out-of-range beat still lets a simultaneous drain empty it.
    if (acc && in_range) begin
      data_d = d_i;
      ch_d   = tgt;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // Output stage register {data, ch, full} plus the drop-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  assign y_o   = data_q;
  assign ch_o  = ch_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Scoreboard bench: three demux instances (SELECT N=8, SELECT N=6, RR N=6).
module tb_demux_stream_1ton;

  logic       clk;
  logic       rst_n;
  logic [7:0] d     [3];
  logic [2:0] sel   [3];
  logic       v     [3];
  logic       rdy   [3];
  logic [7:0] yo    [3];
  logic [7:0] yv    [3];
  logic [7:0] yr    [3];
  logic [2:0] ch    [3];
  logic       err   [3];

  int total = 0;
  int bad   = 0;

  // Reference state: beats expected out, in order, as (channel << 8) | data.
  int q [3][$];
  int rr_cnt   [3];
  int err_next [3];
  int err_prev [3];
  int rdy_s    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NCH = (g == 0) ? 8 : 6;
    localparam int unsigned MD  = (g == 2) ? 1 : 0;
    logic [NCH-1:0] yv_w;
    demux_stream_1ton #(
      .DATA_W (8),
      .N_CH   (NCH),
      .MODE   (MD)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_i       (d[g]),
      .sel_i     (sel[g]),
      .valid_i   (v[g]),
      .ready_o   (rdy[g]),
      .y_o       (yo[g]),
      .y_valid_o (yv_w),
      .y_ready_i (yr[g][NCH-1:0]),
      .ch_o      (ch[g]),
      .err_o     (err[g])
    );
    assign yv[g] = 8'(yv_w);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nch(input int g);
    return (g == 0) ? 8 : 6;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs set; checks ready, records accepts, returns at next negedge.
  task automatic tick();
    #2;
    for (int g = 0; g < 3; g++) begin
      int full_m;
      int hc;
      int drain_m;
      int tc;
      rdy_s[g] = int'(rdy[g]);
      if (rst_n) begin
        full_m  = (q[g].size() != 0) ? 1 : 0;
        hc      = full_m ? (q[g][0] >> 8) : 0;
        drain_m = (full_m != 0 && yr[g][hc] == 1'b1) ? 1 : 0;
        chk("ready", int'(rdy[g]), (full_m == 0 || drain_m != 0) ? 1 : 0);
        if (v[g] && rdy[g]) begin
          if (g == 2) begin
            tc = rr_cnt[g] % nch(g);
            rr_cnt[g]++;
          end else begin
            tc = int'(sel[g]);
          end
          if (tc >= nch(g)) err_next[g] = 1;
          else q[g].push_back((tc << 8) | int'(d[g]));
        end
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every cycle check the presented beat against the scoreboard head and pop on drain.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        for (int g = 0; g < 3; g++) begin
          chk("err_pulse", int'(err[g]), err_prev[g]);
          err_prev[g] = err_next[g];
          err_next[g] = 0;
          chk("onehot", (yv[g] == 8'h00 ||
                         (int'(ch[g]) < nch(g) && yv[g] == (8'h01 << ch[g]))) ? 1 : 0, 1);
          if (yv[g] != 8'h00) begin
            if (q[g].size() == 0) begin
              chk("spurious_beat", int'(yv[g]), 0);
            end else begin
              chk("beat", (int'(ch[g]) << 8) | int'(yo[g]), q[g][0]);
              if ((yv[g] & yr[g]) != 8'h00) void'(q[g].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      d[g] = '0; sel[g] = '0; v[g] = 1'b0; yr[g] = '0;
      rr_cnt[g] = 0; err_next[g] = 0; err_prev[g] = 0; rdy_s[g] = 0;
    end
    #2;
    for (int g = 0; g < 3; g++) begin
      chk("rst_valid", int'(yv[g]), 0);
      chk("rst_y", int'(yo[g]), 0);
      chk("rst_ch", int'(ch[g]), 0);
      chk("rst_err", int'(err[g]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk("rst_ready", int'(rdy[g]), 1);
    @(negedge clk);

    // Back-to-back SELECT beats, all downstream ready.
    yr[0] = 8'hFF;
    v[0] = 1'b1; d[0] = 8'hA5; sel[0] = 3'd3;
    tick();
    chk("t1_ready0", rdy_s[0], 1);
    chk("t1_valid0", int'(yv[0]), 8'h08);
    chk("t1_y0", int'(yo[0]), 8'hA5);
    d[0] = 8'h5A; sel[0] = 3'd7;
    tick();
    chk("t1_ready1", rdy_s[0], 1);
    chk("t1_valid1", int'(yv[0]), 8'h80);
    chk("t1_y1", int'(yo[0]), 8'h5A);
    v[0] = 1'b0;
    tick();
    chk("t1_idle", int'(yv[0]), 0);

    // Head-of-line stall on channel 3 blocks a beat for channel 0.
    yr[0] = 8'hF7;
    v[0] = 1'b1; d[0] = 8'h11; sel[0] = 3'd3;
    tick();
    chk("t2_valid_a", int'(yv[0]), 8'h08);
    d[0] = 8'h22; sel[0] = 3'd0;
    tick();
    chk("t2_stall_ready", rdy_s[0], 0);
    chk("t2_held_valid", int'(yv[0]), 8'h08);
    chk("t2_held_y", int'(yo[0]), 8'h11);
    yr[0] = 8'hFF;
    tick();
    chk("t2_release_ready", rdy_s[0], 1);
    chk("t2_valid_b", int'(yv[0]), 8'h01);
    chk("t2_y_b", int'(yo[0]), 8'h22);
    v[0] = 1'b0;
    tick();

    // Round-robin on 6 channels wraps after channel 5.
    yr[2] = 8'hFF;
    v[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[2] = 8'(i);
      tick();
      chk("t3_ch", int'(ch[2]), i % 6);
      chk("t3_valid", int'(yv[2]), 1 << (i % 6));
      chk("t3_y", int'(yo[2]), i);
    end
    v[2] = 1'b0;
    tick();

    // Out-of-range select on 6 channels: accepted, dropped, one error pulse.
    yr[1] = 8'hFF;
    v[1] = 1'b1; d[1] = 8'h33; sel[1] = 3'd6;
    tick();
    chk("t4_ready", rdy_s[1], 1);
    chk("t4_err", int'(err[1]), 1);
    chk("t4_valid", int'(yv[1]), 0);
    v[1] = 1'b0;
    tick();
    chk("t4_err_clear", int'(err[1]), 0);
    chk("t4_valid_after", int'(yv[1]), 0);

    // Asynchronous reset drops a held beat immediately.
    yr[0] = 8'h00;
    v[0] = 1'b1; d[0] = 8'h77; sel[0] = 3'd2;
    tick();
    v[0] = 1'b0;
    chk("t5_held", int'(yv[0]), 8'h04);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", int'(yv[0]), 0);
    for (int g = 0; g < 3; g++) begin
      q[g].delete();
      rr_cnt[g] = 0; err_next[g] = 0; err_prev[g] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    yr[0] = 8'hFF;
    v[0] = 1'b1; d[0] = 8'h44; sel[0] = 3'd4;
    tick();
    chk("t5_valid_after", int'(yv[0]), 8'h10);
    chk("t5_y_after", int'(yo[0]), 8'h44);
    v[0] = 1'b0;
    tick();

    // Random traffic on all instances.
    for (int n = 0; n < 10000; n++) begin
      for (int g = 0; g < 3; g++) begin
        v[g]   = ($urandom_range(0, 3) != 0);
        d[g]   = 8'($urandom);
        sel[g] = 3'($urandom_range(0, 7));
        for (int b = 0; b < 8; b++) yr[g][b] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    // Drain everything and confirm nothing was lost.
    for (int g = 0; g < 3; g++) begin
      v[g] = 1'b0;
      yr[g] = 8'hFF;
    end
    for (int n = 0; n < 8; n++) tick();
    for (int g = 0; g < 3; g++) chk("drained", q[g].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
